// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default datapath widths and the
// occupancy encoding of the two-entry skid buffers between stages.
package cpu_pkg;

    localparam int unsigned DataWDef  = 32;
    localparam int unsigned RaddrWDef = 5;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer (head + skid) with an opaque payload. in_ready depends
// only on registered occupancy, so there is no combinational path from out_ready.
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    occ_state_e             state_q, state_d;
    logic [PAYLOAD_W-1:0]   head_q, head_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   push;
    logic                   pop;

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        head_d  = in_data;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        head_d = in_data;
                    end else if (push) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // No push possible here; in_ready is low in this state.
                    if (pop) begin
                        state_d = StOne;
                        head_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built on a two-entry skid buffer, with head-entry
// forwarding and optional signed-overflow trapping (macro EX_MEM_OVF_TRAP_EN).
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = DataWDef,
    parameter int unsigned RADDR_W = RaddrWDef
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_overflow,
    input  logic               ovf_check,
    input  logic [DATA_W-1:0]  store_data,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [DATA_W-1:0]  pc,
    input  logic               flush,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [DATA_W-1:0]  out_store_data,
    output logic [RADDR_W-1:0] out_rd_addr,
    output logic               out_reg_write,
    output logic               out_mem_read,
    output logic               out_mem_write,

    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd_addr,
    output logic [DATA_W-1:0]  fwd_data,

    output logic               exc_valid,
    output logic [DATA_W-1:0]  exc_epc
);

    localparam int unsigned PayloadW = 2 * DATA_W + RADDR_W + 3;

    logic                trap;
    logic [PayloadW-1:0] in_payload;
    logic [PayloadW-1:0] head_payload;
    logic                buf_valid;

    logic [DATA_W-1:0]   head_result;
    logic [DATA_W-1:0]   head_store_data;
    logic [RADDR_W-1:0]  head_rd_addr;
    logic                head_reg_write;
    logic                head_mem_read;
    logic                head_mem_write;

`ifdef EX_MEM_OVF_TRAP_EN
    logic                accept;
    logic                exc_valid_q;
    logic [DATA_W-1:0]   exc_epc_q;

    assign trap   = ovf_check && alu_overflow;
    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_valid_q <= 1'b0;
            exc_epc_q   <= '0;
        end else begin
            exc_valid_q <= accept && trap;
            if (accept && trap) begin
                exc_epc_q <= pc;
            end
        end
    end

    assign exc_valid = exc_valid_q;
    assign exc_epc   = exc_epc_q;
`else
    logic unused_ovf;

    assign trap       = 1'b0;
    assign unused_ovf = ^{alu_overflow, ovf_check, pc};
    assign exc_valid  = 1'b0;
    assign exc_epc    = '0;
`endif

    // A trapping instruction still occupies its slot but must not write anything.
    assign in_payload = {alu_result, store_data, rd_addr,
                         reg_write && !trap, mem_read && !trap, mem_write && !trap};

    pipe_skid_buf #(
        .PAYLOAD_W (PayloadW)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (head_payload)
    );

    assign {head_result, head_store_data, head_rd_addr,
            head_reg_write, head_mem_read, head_mem_write} = head_payload;

    // Every head field reads as zero while the stage is empty.
    always_comb begin
        out_valid      = buf_valid;
        out_result     = '0;
        out_store_data = '0;
        out_rd_addr    = '0;
        out_reg_write  = 1'b0;
        out_mem_read   = 1'b0;
        out_mem_write  = 1'b0;
        if (buf_valid) begin
            out_result     = head_result;
            out_store_data = head_store_data;
            out_rd_addr    = head_rd_addr;
            out_reg_write  = head_reg_write;
            out_mem_read   = head_mem_read;
            out_mem_write  = head_mem_write;
        end
    end

    // Loads are not forwardable from here; their data arrives from MEM.
    assign fwd_valid   = out_valid && out_reg_write && !out_mem_read && (out_rd_addr != '0);
    assign fwd_rd_addr = out_rd_addr;
    assign fwd_data    = out_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [DW-1:0] alu_result;
    logic          alu_overflow, ovf_check;
    logic [DW-1:0] store_data;
    logic [AW-1:0] rd_addr;
    logic          reg_write, mem_read, mem_write;
    logic [DW-1:0] pc;
    logic          flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_result, out_store_data;
    logic [AW-1:0] out_rd_addr;
    logic          out_reg_write, out_mem_read, out_mem_write;
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd_addr;
    logic [DW-1:0] fwd_data;
    logic          exc_valid;
    logic [DW-1:0] exc_epc;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow),
        .ovf_check      (ovf_check),
        .store_data     (store_data),
        .rd_addr        (rd_addr),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .pc             (pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_rd_addr    (out_rd_addr),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .fwd_valid      (fwd_valid),
        .fwd_rd_addr    (fwd_rd_addr),
        .fwd_data       (fwd_data),
        .exc_valid      (exc_valid),
        .exc_epc        (exc_epc)
    );

    always #5 clk = ~clk;

`ifdef EX_MEM_OVF_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] result;
        logic [DW-1:0] sdata;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          mw;
    } entry_t;

    entry_t        q[$];
    logic          exp_exc;
    logic [DW-1:0] exp_epc;
    bit            live = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries, updated from pre-edge inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_exc = 1'b0;
            exp_epc = '0;
            live    = 1;
        end else if (flush) begin
            q.delete();
            exp_exc = 1'b0;
        end else begin
            bit do_push, do_pop, trap;
            entry_t e;
            do_push = in_valid && (q.size() < 2);
            do_pop  = (q.size() > 0) && out_ready;
            trap    = TrapEn && ovf_check && alu_overflow;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.result = alu_result;
                e.sdata  = store_data;
                e.rd     = rd_addr;
                e.rw     = reg_write && !trap;
                e.mr     = mem_read && !trap;
                e.mw     = mem_write && !trap;
                q.push_back(e);
            end
            exp_exc = do_push && trap;
            if (do_push && trap) exp_epc = pc;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            bit v;
            v = (q.size() > 0);
            chk("m_out_valid", 64'(out_valid), 64'(v));
            chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("m_exc_valid", 64'(exc_valid), 64'(exp_exc));
            chk("m_exc_epc", 64'(exc_epc), 64'(exp_epc));
            if (v) begin
                chk("m_out_result", 64'(out_result), 64'(q[0].result));
                chk("m_out_store_data", 64'(out_store_data), 64'(q[0].sdata));
                chk("m_out_rd_addr", 64'(out_rd_addr), 64'(q[0].rd));
                chk("m_out_flags", 64'({out_reg_write, out_mem_read, out_mem_write}),
                    64'({q[0].rw, q[0].mr, q[0].mw}));
                chk("m_fwd_valid", 64'(fwd_valid),
                    64'(q[0].rw && !q[0].mr && (q[0].rd != 0)));
                chk("m_fwd_rd_addr", 64'(fwd_rd_addr), 64'(q[0].rd));
                chk("m_fwd_data", 64'(fwd_data), 64'(q[0].result));
            end else begin
                chk("m_idle_flags", 64'({out_reg_write, out_mem_read, out_mem_write}), 64'(0));
                chk("m_idle_fwd", 64'(fwd_valid), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] res, input logic [AW-1:0] rd,
                         input logic rw, input logic mr);
        in_valid     = 1'b1;
        alu_result   = res;
        store_data   = res ^ 32'hFFFF_0000;
        rd_addr      = rd;
        reg_write    = rw;
        mem_read     = mr;
        mem_write    = 1'b0;
        alu_overflow = 1'b0;
        ovf_check    = 1'b0;
        pc           = 32'h0040_0000;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        alu_result = '0; store_data = '0; rd_addr = '0; reg_write = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; pc = '0; alu_overflow = 1'b0; ovf_check = 1'b0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_exc_epc", 64'(exc_epc), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        rst_n = 1'b1;

        // Streaming: 1-cycle latency, back-to-back
        for (int i = 1; i <= 4; i++) begin
            offer(32'(i), 5'(i), 1'b1, 1'b0);
            step();
            chk("stream_result", 64'(out_result), 64'(i));
            chk("stream_in_ready", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 64'(out_valid), 64'(0));

        // Backpressure: third offer refused at TWO
        out_ready = 1'b0;
        offer(32'h11, 5'd1, 1'b1, 1'b0); step();
        offer(32'h12, 5'd2, 1'b1, 1'b0); step();
        chk("bp_in_ready_two", 64'(in_ready), 64'(0));
        offer(32'h13, 5'd3, 1'b1, 1'b0); step();
        chk("bp_head_held", 64'(out_result), 64'(32'h11));
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_second", 64'(out_result), 64'(32'h12));
        chk("bp_in_ready_after_pop", 64'(in_ready), 64'(1));
        step();
        chk("bp_drained", 64'(out_valid), 64'(0));

        // Forwarding
        out_ready = 1'b0;
        offer(32'hDEAD, 5'd5, 1'b1, 1'b0); step();
        chk("fwd_valid_rd5", 64'(fwd_valid), 64'(1));
        chk("fwd_data", 64'(fwd_data), 64'(32'hDEAD));
        chk("fwd_rd_addr", 64'(fwd_rd_addr), 64'(5));
        out_ready = 1'b1;
        offer(32'hDEAD, 5'd0, 1'b1, 1'b0); step();
        chk("fwd_valid_rd0", 64'(fwd_valid), 64'(0));
        offer(32'hDEAD, 5'd5, 1'b1, 1'b1); step();
        chk("fwd_valid_load", 64'(fwd_valid), 64'(0));
        in_valid = 1'b0; step();

        // Overflow: 0x7FFFFFFF + 1
        out_ready = 1'b0;
        offer(32'h8000_0000, 5'd7, 1'b1, 1'b0);
        alu_overflow = 1'b1; ovf_check = 1'b1; pc = 32'h0040_0010;
        step();
        in_valid = 1'b0; alu_overflow = 1'b0; ovf_check = 1'b0;
        chk("ovf_exc_valid", 64'(exc_valid), 64'(TrapEn ? 1 : 0));
        chk("ovf_exc_epc", 64'(exc_epc), 64'(TrapEn ? 32'h0040_0010 : 32'h0));
        chk("ovf_reg_write", 64'(out_reg_write), 64'(TrapEn ? 0 : 1));
        step();
        chk("ovf_exc_pulse_end", 64'(exc_valid), 64'(0));
        out_ready = 1'b1; step();

        // Flush in TWO with a concurrent (overflowing) offer
        out_ready = 1'b0;
        offer(32'h21, 5'd1, 1'b1, 1'b0); step();
        offer(32'h22, 5'd2, 1'b1, 1'b0); step();
        offer(32'h23, 5'd3, 1'b1, 1'b0);
        alu_overflow = 1'b1; ovf_check = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; alu_overflow = 1'b0; ovf_check = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        chk("flush_no_exc", 64'(exc_valid), 64'(0));
        step();

        // Reset in TWO with a concurrent offer
        offer(32'h31, 5'd1, 1'b1, 1'b0); step();
        offer(32'h32, 5'd2, 1'b1, 1'b0); step();
        rst_n = 1'b0;
        offer(32'h33, 5'd3, 1'b1, 1'b0); step();
        chk("rst2_out_valid", 64'(out_valid), 64'(0));
        chk("rst2_in_ready", 64'(in_ready), 64'(1));
        chk("rst2_outs", 64'({out_result, out_rd_addr, out_reg_write, fwd_valid}), 64'(0));
        chk("rst2_exc", 64'({exc_valid, exc_epc}), 64'(0));
        rst_n = 1'b1; out_ready = 1'b1;
        offer(32'h55, 5'd4, 1'b1, 1'b0); step();
        chk("rst2_latency", 64'({out_valid, out_result}), 64'({1'b1, 32'h55}));
        in_valid = 1'b0; step();
        chk("rst2_drained", 64'(out_valid), 64'(0));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of result, store data and PC.
REQ-002 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-004 SHALL have these upstream ports:
- in_valid input 1: upstream entry valid.
- in_ready output 1: stage can accept.
- alu_result input DATA_W: ALU result.
- alu_overflow input 1: ALU signed overflow.
- ovf_check input 1: instruction is trapping ADD/SUB/ADDI.
- store_data input DATA_W: rt value for stores.
- rd_addr input RADDR_W: destination register.
- reg_write input 1: writeback enable.
- mem_read input 1: load.
- mem_write input 1: store.
- pc input DATA_W: instruction PC.
- flush input 1: squash all entries.
REQ-005 SHALL have these downstream ports:
- out_valid output 1: head entry valid.
- out_ready input 1: MEM stage accepts head.
- out_result, out_store_data output DATA_W: head fields.
- out_rd_addr output RADDR_W: head field.
- out_reg_write, out_mem_read, out_mem_write output 1: head fields.
REQ-006 SHALL have these forwarding and exception ports:
- fwd_valid output 1: head forwardable.
- fwd_rd_addr output RADDR_W: head rd.
- fwd_data output DATA_W: head result.
- exc_valid output 1: overflow trap pulse.
- exc_epc output DATA_W: PC of trapping instruction.

Function
REQ-007 SHALL be a 2-entry skid buffer (head, skid); occupancy FSM states EMPTY, ONE, TWO.
REQ-008 SHALL accept on in_valid&&in_ready; SHALL pop head on out_valid&&out_ready.
REQ-009 SHALL drive in_ready = (state!=TWO), registered-state-derived, with no combinational path from out_ready.
REQ-010 SHALL follow these transitions: EMPTY+push->ONE; ONE+push without pop->TWO; ONE+pop without push->EMPTY; ONE+push+pop->ONE with the new entry at head; TWO+pop->ONE with skid moved to head; otherwise hold.
REQ-011 SHALL have latency 1: an entry accepted in an EMPTY cycle appears on out_* the next cycle.
REQ-012 SHALL hold out_valid=1 and all head fields stable while out_valid&&!out_ready.
REQ-013 SHALL drive out_valid=(state!=EMPTY) and SHALL preserve strict FIFO order.
REQ-014 SHALL drive fwd_valid = out_valid && out_reg_write && !out_mem_read && out_rd_addr!=0; fwd_rd_addr=out_rd_addr; fwd_data=out_result.
REQ-015 SHALL give flush priority: the next state is EMPTY, the in_valid entry of that cycle is dropped, and no exc_valid results from it.
REQ-016 SHALL zero out_reg_write, out_mem_read and out_mem_write whenever out_valid=0.

Reset
REQ-017 SHALL, when rst_n=0 at a clk edge, make state EMPTY; all out_*, fwd_*, exc_valid and exc_epc 0; in_ready 1 the following cycle.
REQ-018 SHALL discard entries on reset mid-operation and treat the upstream entry of that cycle as not accepted.

Configuration
REQ-019 SHALL compile in, with macro EX_MEM_OVF_TRAP_EN defined, overflow trapping: on push with ovf_check&&alu_overflow&&!flush, the entry SHALL be stored with reg_write, mem_read and mem_write cleared, exc_valid SHALL pulse exactly one cycle, and exc_epc SHALL be loaded with pc.
REQ-020 SHALL, with EX_MEM_OVF_TRAP_EN undefined, ignore alu_overflow and ovf_check and tie exc_valid and exc_epc to 0.

Structure
REQ-021 SHALL place the occupancy-state enum (EMPTY/ONE/TWO) and the default widths in shared package cpu_pkg.
REQ-022 SHALL keep the entry storage in one sub-module, pipe_skid_buf, with an entry-wide payload parameter; overflow and forwarding logic stays in ex_mem_stage.

Verification
REQ-023 SHALL verify streaming: in_valid=1 with out_ready=1 for 4 results 0x1..0x4 -> out_result 0x1..0x4 on consecutive cycles starting 1 cycle later, in_ready constantly 1.
REQ-024 SHALL verify backpressure: out_ready=0 with 3 offered entries -> 2 accepted, in_ready=0 at TWO; out_ready=1 -> order preserved, in_ready=1 after the first pop.
REQ-025 SHALL verify forwarding: head rd=5, reg_write=1, mem_read=0, result 0xDEAD -> fwd_valid=1, fwd_data=0xDEAD; the same entry with rd=0 or mem_read=1 -> fwd_valid=0.
REQ-026 SHALL verify overflow (macro defined): ADD of 0x7FFFFFFF+1 with ovf_check=1, pc=0x400010 -> exc_valid for 1 cycle, exc_epc=0x400010, out_reg_write=0; macro undefined -> exc_valid=0, out_reg_write=1.
REQ-027 SHALL verify flush: flush in state TWO together with in_valid -> out_valid=0 next cycle, in_ready=1, no exc_valid.
REQ-028 SHALL verify reset: rst_n=0 in state TWO -> all outputs 0 next cycle; rst_n=1 then push -> normal 1-cycle latency.
